mc_controller_v2: RTL and testbench
===================================

Name: mc_controller_v2

Overview:
- Parametrised second-generation control unit for the multicycle RISC-V core; drives the shared-memory datapath (PC, IR, OldPC, ALUOut, Data registers).
- Extends the first-generation controller with:
  - I-type ALU, LUI, JAL, BNE/BLT/BGE.
  - Variable-latency memory handshake.
  - Memory watchdog and illegal-instruction trap state.
  - Selectable 3- or 4-bit ALU control encoding.

Parameters:
- ALUCTRL_W, 3, width of ALUControl; 3 = add/sub/and/or/slt only; 4 = adds xor/sll/srl/sra.
- MEM_TIMEOUT, 0, max cycles waiting on mem_ready before trapping; 0 disables the watchdog.
- TMO_W, 8, width of the watchdog counter; MEM_TIMEOUT < 2**TMO_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed rs1 < rs2 from ALU.
- mem_ready  in  1  memory completes the current access this cycle.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero.
- ALUSrcB  out  2  00 RD2, 01 Imm, 10 const 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc  out  1  0 PC, 1 Result.
- ALUControl  out  ALUCTRL_W  ALU operation.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables.
- MemReq  out  1  memory access request.
- trap  out  1  controller halted (illegal instruction or timeout).
- state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 15.
- Reset: reset=0 forces state=FETCH, watchdog=0, and all write enables/MemReq/trap=0 asynchronously. Operation resumes on the first clk edge after release.
- Outputs are combinational from state (plus mem_ready, Zero, Lt where noted). Unlisted outputs are 0; ALUControl defaults to add (0).
- FETCH:
  - Drives MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 0110111 -> LUI.
  - any other op -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Waits on mem_ready, then goes to MEMWB.
- MEMWRITE: MemReq=1, AdrSrc=1, ResultSrc=00, MemWrite=mem_ready. Waits on mem_ready, then goes to FETCH.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- EXECR / EXECI: ALUSrcA=10; ALUSrcB=00 for EXECR, 01 for EXECI; then ALUWB.
  - funct3 000: sub only when R-type and funct7b5=1, else add.
  - 010 slt, 110 or, 111 and.
  - ALUCTRL_W=4 only: 100 xor; 001 sll; 101 srl, or sra when funct7b5=1.
  - Unsupported funct3 at ALUCTRL_W=3 -> TRAP instead of ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH.
  - PCWrite=taken, where 000 taken=Zero, 001 !Zero, 100 Lt, 101 !Lt.
  - Any other funct3 -> TRAP with PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (target from ALUOut); then ALUWB (writes PC+4).
- LUI: ImmSrc=100, ALUSrcA=11, ALUSrcB=01, add, then ALUWB.
- ImmSrc per op: I for load/EXECI, S for store, B for branch, J for JAL, U for LUI.
- Watchdog:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0; clears on any state change.
  - With MEM_TIMEOUT>0, reaching MEM_TIMEOUT with mem_ready=0 moves to TRAP next edge.
  - mem_ready=1 on the same cycle wins; no trap.
- TRAP: trap=1, all write enables and MemReq=0. Stays until reset.
- Unknown inputs (X on op) before the first fetch completes have no effect; op is sampled only in DECODE.

Optional Feature:
- CTRL_PERF_CNT_EN: adds output instret (32 bits), reset to 0.
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; wraps 0xFFFFFFFF -> 0.
  - Without the macro the port and counter do not exist.

Test Plan:
- lw, mem_ready=1 always -> states 0,1,2,3,4,0 (5 cycles); RegWrite=1 only in MEMWB with ResultSrc=01.
- R-type funct3=000, funct7b5=1 -> ALUControl=001 in EXECR; funct7b5=0 -> 000; ALUWB asserts RegWrite.
- beq then bne with Zero=1 -> PCWrite=1 in BRANCH for beq, 0 for bne; blt with Lt=1 -> PCWrite=1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, trap=1; second run raising mem_ready in the 4th cycle -> DECODE, no trap.
- op=1111111 in DECODE -> TRAP; reset=0 mid-MEMREAD -> state_o=0 immediately, MemReq=0 while held.
- CTRL_PERF_CNT_EN defined, 3 instructions (lw, add, beq) -> instret=3.

Source files
------------

// File: rtl/mc_controller_v2.sv
// Multicycle RISC-V control FSM with variable-latency memory handshake, watchdog and trap state.
// Optional macro CTRL_PERF_CNT_EN adds a 32-bit retired-instruction counter output (instret).
module mc_controller_v2 #(
   parameter int ALUCTRL_W   = 3,
   parameter int MEM_TIMEOUT = 0,
   parameter int TMO_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 Zero,
   input  logic                 Lt,
   input  logic                 mem_ready,
   output logic [2:0]           ImmSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ResultSrc,
   output logic                 AdrSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic                 MemReq,
   output logic                 trap,
   output logic [3:0]           state_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]          instret
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RALU  = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic             W4       = (ALUCTRL_W == 4);
   localparam logic             TMO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   // Returns {supported, alu_code}; shifts and xor exist only in the 4-bit encoding.
   function automatic logic [4:0] exec_decode(input logic [2:0] f3, input logic f7, input logic rtype);
      logic [4:0] r;
      r = {1'b0, ALU_ADD};
      case (f3)
         3'b000:  r = {1'b1, (rtype && f7) ? ALU_SUB : ALU_ADD};
         3'b010:  r = {1'b1, ALU_SLT};
         3'b110:  r = {1'b1, ALU_OR};
         3'b111:  r = {1'b1, ALU_AND};
         3'b100:  r = {W4, ALU_XOR};
         3'b001:  r = {W4, ALU_SLL};
         3'b101:  r = {W4, f7 ? ALU_SRA : ALU_SRL};
         default: r = {1'b0, ALU_ADD};
      endcase
      return r;
   endfunction

   // Returns {supported, taken}.
   function automatic logic [1:0] branch_decode(input logic [2:0] f3, input logic z, input logic lt);
      logic [1:0] r;
      case (f3)
         3'b000:  r = {1'b1, z};
         3'b001:  r = {1'b1, ~z};
         3'b100:  r = {1'b1, lt};
         3'b101:  r = {1'b1, ~lt};
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] imm_for_op(input logic [6:0] o);
      logic [2:0] r;
      case (o)
         OP_LOAD, OP_IALU: r = 3'b000;
         OP_STORE:         r = 3'b001;
         OP_BR:            r = 3'b010;
         OP_JAL:           r = 3'b011;
         OP_LUI:           r = 3'b100;
         default:          r = 3'b000;
      endcase
      return r;
   endfunction

   state_t           state_q, state_d, nxt_s;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             store_q, store_d;
   logic             wait_s, tmo_hit_s;
   logic [4:0]       ex_s;
   logic [1:0]       br_s;
   logic [2:0]       imm_s;
   logic [1:0]       srca_s, srcb_s, res_s;
   logic             adr_s, irw_s, pcw_s, rw_s, mw_s, mreq_s, trap_s;
   logic [3:0]       alu_s;

   assign ex_s      = exec_decode(funct3, funct7b5, state_q == S_EXECR);
   assign br_s      = branch_decode(funct3, Zero, Lt);
   assign wait_s    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
   assign tmo_hit_s = TMO_EN && wait_s && !mem_ready && (tmo_q == TMO_LAST);
   assign state_d   = tmo_hit_s ? S_TRAP : nxt_s;
   assign store_d   = (state_q == S_DECODE) ? (op == OP_STORE) : store_q;
   assign tmo_d     = (state_d != state_q) ? '0 :
                      (wait_s && !mem_ready) ? tmo_q + TMO_W'(1) : tmo_q;

   always_comb begin
      nxt_s  = state_q;
      imm_s  = 3'b000;
      srca_s = 2'b00;
      srcb_s = 2'b00;
      res_s  = 2'b00;
      adr_s  = 1'b0;
      alu_s  = ALU_ADD;
      irw_s  = 1'b0;
      pcw_s  = 1'b0;
      rw_s   = 1'b0;
      mw_s   = 1'b0;
      mreq_s = 1'b0;
      trap_s = 1'b0;
      case (state_q)
         S_FETCH: begin
            mreq_s = 1'b1;
            srcb_s = 2'b10;
            res_s  = 2'b10;
            irw_s  = mem_ready;
            pcw_s  = mem_ready;
            nxt_s  = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            srca_s = 2'b01;
            srcb_s = 2'b01;
            imm_s  = imm_for_op(op);
            case (op)
               OP_LOAD, OP_STORE: nxt_s = S_MEMADR;
               OP_RALU:           nxt_s = S_EXECR;
               OP_IALU:           nxt_s = S_EXECI;
               OP_BR:             nxt_s = S_BRANCH;
               OP_JAL:            nxt_s = S_JAL;
               OP_LUI:            nxt_s = S_LUI;
               default:           nxt_s = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            srca_s = 2'b10;
            srcb_s = 2'b01;
            imm_s  = store_q ? 3'b001 : 3'b000;
            nxt_s  = store_q ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mreq_s = 1'b1;
            adr_s  = 1'b1;
            nxt_s  = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWRITE: begin
            mreq_s = 1'b1;
            adr_s  = 1'b1;
            mw_s   = mem_ready;
            nxt_s  = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_MEMWB: begin
            res_s = 2'b01;
            rw_s  = 1'b1;
            nxt_s = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            srca_s = 2'b10;
            srcb_s = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            alu_s  = ex_s[3:0];
            nxt_s  = ex_s[4] ? S_ALUWB : S_TRAP;
         end
         S_ALUWB: begin
            rw_s  = 1'b1;
            nxt_s = S_FETCH;
         end
         S_BRANCH: begin
            srca_s = 2'b10;
            alu_s  = ALU_SUB;
            imm_s  = 3'b010;
            pcw_s  = br_s[1] & br_s[0];
            nxt_s  = br_s[1] ? S_FETCH : S_TRAP;
         end
         S_JAL: begin
            srca_s = 2'b01;
            srcb_s = 2'b10;
            imm_s  = 3'b011;
            pcw_s  = 1'b1;
            nxt_s  = S_ALUWB;
         end
         S_LUI: begin
            imm_s  = 3'b100;
            srca_s = 2'b11;
            srcb_s = 2'b01;
            nxt_s  = S_ALUWB;
         end
         S_TRAP: begin
            trap_s = 1'b1;
            nxt_s  = S_TRAP;
         end
         default: nxt_s = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         tmo_q   <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         store_q <= store_d;
      end
   end

   // Strobes are forced low combinationally while reset is held.
   assign ImmSrc     = imm_s;
   assign ALUSrcA    = srca_s;
   assign ALUSrcB    = srcb_s;
   assign ResultSrc  = res_s;
   assign AdrSrc     = adr_s;
   assign ALUControl = alu_s[ALUCTRL_W-1:0];
   assign IRWrite    = irw_s & reset;
   assign PCWrite    = pcw_s & reset;
   assign RegWrite   = rw_s & reset;
   assign MemWrite   = mw_s & reset;
   assign MemReq     = mreq_s & reset;
   assign trap       = trap_s & reset;
   assign state_o    = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instret_q;
   logic        retire_s;

   assign retire_s = (state_d == S_FETCH) &&
                     ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                      (state_q == S_ALUWB) || (state_q == S_BRANCH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instret_q <= 32'd0;
      end else if (retire_s) begin
         instret_q <= instret_q + 32'd1;
      end else begin
         instret_q <= instret_q;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_controller_v2.sv
// Scoreboard bench for mc_controller_v2: a 3-bit instance with a 4-cycle watchdog and a 4-bit
// instance without watchdog run the same directed instruction sequence.
module tb_mc_controller_v2;

   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_J = 7'b1101111;
   localparam logic [6:0] OP_U = 7'b0110111;

   localparam int F_ST = 0, F_IRW = 1, F_PCW = 2, F_RW = 3, F_MW = 4, F_MREQ = 5, F_TRAP = 6;
   localparam int F_ALUC = 7, F_RES = 8, F_SRCA = 9, F_SRCB = 10, F_IMM = 11, F_ADR = 12, F_IRET = 13;

   typedef struct {
      string       tag;
      int          sel;
      bit          d4;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, funct7b5, Zero, Lt, mem_ready;
   logic [6:0] op;
   logic [2:0] funct3;

   logic [2:0] a_imm, b_imm;
   logic [1:0] a_srca, a_srcb, a_res, b_srca, b_srcb, b_res;
   logic       a_adr, a_irw, a_pcw, a_rw, a_mw, a_mreq, a_trap;
   logic       b_adr, b_irw, b_pcw, b_rw, b_mw, b_mreq, b_trap;
   logic [2:0] a_aluc;
   logic [3:0] b_aluc, a_st, b_st;
   logic [31:0] a_iret, b_iret;

   mc_controller_v2 #(.ALUCTRL_W(3), .MEM_TIMEOUT(4), .TMO_W(8)) u_dut3 (
`ifdef CTRL_PERF_CNT_EN
      .instret(a_iret),
`endif
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .mem_ready(mem_ready),
      .ImmSrc(a_imm), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ResultSrc(a_res), .AdrSrc(a_adr),
      .ALUControl(a_aluc), .IRWrite(a_irw), .PCWrite(a_pcw), .RegWrite(a_rw), .MemWrite(a_mw),
      .MemReq(a_mreq), .trap(a_trap), .state_o(a_st)
   );

   mc_controller_v2 #(.ALUCTRL_W(4), .MEM_TIMEOUT(0), .TMO_W(8)) u_dut4 (
`ifdef CTRL_PERF_CNT_EN
      .instret(b_iret),
`endif
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .mem_ready(mem_ready),
      .ImmSrc(b_imm), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ResultSrc(b_res), .AdrSrc(b_adr),
      .ALUControl(b_aluc), .IRWrite(b_irw), .PCWrite(b_pcw), .RegWrite(b_rw), .MemWrite(b_mw),
      .MemReq(b_mreq), .trap(b_trap), .state_o(b_st)
   );

`ifndef CTRL_PERF_CNT_EN
   assign a_iret = 32'd0;
   assign b_iret = 32'd0;
`endif

   function automatic logic [31:0] obs(input int sel, input bit d4);
      case (sel)
         F_ST:    return d4 ? 32'(b_st)   : 32'(a_st);
         F_IRW:   return d4 ? 32'(b_irw)  : 32'(a_irw);
         F_PCW:   return d4 ? 32'(b_pcw)  : 32'(a_pcw);
         F_RW:    return d4 ? 32'(b_rw)   : 32'(a_rw);
         F_MW:    return d4 ? 32'(b_mw)   : 32'(a_mw);
         F_MREQ:  return d4 ? 32'(b_mreq) : 32'(a_mreq);
         F_TRAP:  return d4 ? 32'(b_trap) : 32'(a_trap);
         F_ALUC:  return d4 ? 32'(b_aluc) : 32'(a_aluc);
         F_RES:   return d4 ? 32'(b_res)  : 32'(a_res);
         F_SRCA:  return d4 ? 32'(b_srca) : 32'(a_srca);
         F_SRCB:  return d4 ? 32'(b_srcb) : 32'(a_srcb);
         F_IMM:   return d4 ? 32'(b_imm)  : 32'(a_imm);
         F_ADR:   return d4 ? 32'(b_adr)  : 32'(a_adr);
         F_IRET:  return d4 ? b_iret      : a_iret;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic e(input string tag, input int sel, input logic [31:0] v);
      exp_t x;
      x.tag = tag; x.sel = sel; x.d4 = 1'b0; x.val = v;
      q.push_back(x);
   endtask

   task automatic e4(input string tag, input int sel, input logic [31:0] v);
      exp_t x;
      x.tag = tag; x.sel = sel; x.d4 = 1'b1; x.val = v;
      q.push_back(x);
   endtask

   task automatic chk();
      exp_t        x;
      logic [31:0] o;
      #1;
      while (q.size() > 0) begin
         x = q.pop_front();
         o = obs(x.sel, x.d4);
         n_checks = n_checks + 1;
         assert (o === x.val) n_pass = n_pass + 1;
         else $error("FAIL %s%s: observed %0h expected %0h", x.d4 ? "w4." : "w3.", x.tag, o, x.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One FETCH cycle with immediate memory completion, then present op in DECODE.
   task automatic fetch(input logic [6:0] opv);
      mem_ready = 1'b1;
      e("fetch_st", F_ST, 32'd0); e("fetch_irw", F_IRW, 32'd1); e4("fetch_st", F_ST, 32'd0);
      chk();
      tick();
      op = opv;
      e("dec_st", F_ST, 32'd1); e("dec_srca", F_SRCA, 32'd1); e4("dec_st", F_ST, 32'd1);
      chk();
   endtask

   task automatic run_lw();
      fetch(OP_L);
      tick(); e("lw_adr_st", F_ST, 32'd2); e("lw_adr_srca", F_SRCA, 32'd2); chk();
      tick(); e("lw_rd_st", F_ST, 32'd3); e("lw_rd_adr", F_ADR, 32'd1); e("lw_rd_rw", F_RW, 32'd0); chk();
      tick(); e("lw_wb_st", F_ST, 32'd4); e("lw_wb_rw", F_RW, 32'd1); e("lw_wb_res", F_RES, 32'd1); chk();
      tick(); e("lw_done_st", F_ST, 32'd0); e("lw_done_rw", F_RW, 32'd0); chk();
   endtask

   task automatic run_r(input logic [2:0] f3, input logic f7, input logic [31:0] exp_alu);
      fetch(OP_R);
      funct3 = f3; funct7b5 = f7;
      tick(); e("r_ex_st", F_ST, 32'd6); e("r_ex_alu", F_ALUC, exp_alu); e("r_ex_srcb", F_SRCB, 32'd0); chk();
      tick(); e("r_wb_st", F_ST, 32'd8); e("r_wb_rw", F_RW, 32'd1); chk();
      tick();
   endtask

   task automatic run_br(input logic [2:0] f3, input logic z, input logic lt, input logic [31:0] exp_pcw);
      fetch(OP_B);
      funct3 = f3; Zero = z; Lt = lt;
      tick(); e("br_st", F_ST, 32'd9); e("br_pcw", F_PCW, exp_pcw); e("br_alu", F_ALUC, 32'd1);
      e4("br_pcw", F_PCW, exp_pcw); chk();
      tick(); e("br_done_st", F_ST, 32'd0); chk();
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b1; op = 7'bx; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; Lt = 1'b0;
      #1 reset = 1'b0;
      e("rst_st", F_ST, 32'd0); e("rst_irw", F_IRW, 32'd0); e("rst_mreq", F_MREQ, 32'd0); e("rst_trap", F_TRAP, 32'd0);
      chk();
      tick();
      reset = 1'b1;
      e("f_mreq", F_MREQ, 32'd1); e("f_pcw", F_PCW, 32'd1); e("f_srcb", F_SRCB, 32'd2); e("f_res", F_RES, 32'd2);
      chk();
      tick();
      e("f2_st", F_ST, 32'd1); chk();
      op = OP_L;
      tick(); e("lw0_st", F_ST, 32'd2); e("lw0_imm", F_IMM, 32'd0); chk();
      tick(); e("lw0_rd_st", F_ST, 32'd3); e("lw0_rd_mreq", F_MREQ, 32'd1); chk();
      tick(); e("lw0_wb_st", F_ST, 32'd4); e("lw0_wb_res", F_RES, 32'd1); e("lw0_wb_rw", F_RW, 32'd1); chk();
      tick(); e("lw0_done", F_ST, 32'd0); chk();

      run_r(3'b000, 1'b1, 32'd1);
      run_r(3'b000, 1'b0, 32'd0);
      run_br(3'b000, 1'b1, 1'b0, 32'd1);
      run_br(3'b001, 1'b1, 1'b0, 32'd0);
      run_br(3'b100, 1'b0, 1'b1, 32'd1);
      run_br(3'b101, 1'b0, 1'b1, 32'd0);

      fetch(OP_S);
      e("sw_dec_imm", F_IMM, 32'd1); chk();
      tick(); e("sw_adr_st", F_ST, 32'd2); e("sw_adr_imm", F_IMM, 32'd1); chk();
      mem_ready = 1'b0;
      tick(); e("sw_wait_st", F_ST, 32'd5); e("sw_wait_mw", F_MW, 32'd0); e("sw_wait_mreq", F_MREQ, 32'd1); chk();
      tick(); e("sw_hold_st", F_ST, 32'd5); chk();
      mem_ready = 1'b1;
      e("sw_mw", F_MW, 32'd1); chk();
      tick(); e("sw_done_st", F_ST, 32'd0); chk();

      fetch(OP_J);
      e("jal_dec_imm", F_IMM, 32'd3); chk();
      tick(); e("jal_st", F_ST, 32'd10); e("jal_pcw", F_PCW, 32'd1); e("jal_srcb", F_SRCB, 32'd2); chk();
      tick(); e("jal_wb_st", F_ST, 32'd8); e("jal_wb_rw", F_RW, 32'd1); chk();
      tick();

      fetch(OP_U);
      tick(); e("lui_st", F_ST, 32'd11); e("lui_imm", F_IMM, 32'd4); e("lui_srca", F_SRCA, 32'd3); chk();
      tick(); e("lui_wb_st", F_ST, 32'd8); chk();
      tick();

      fetch(OP_I);
      funct3 = 3'b000; funct7b5 = 1'b1;
      tick(); e("addi_st", F_ST, 32'd7); e("addi_alu", F_ALUC, 32'd0); e("addi_srcb", F_SRCB, 32'd1);
      e4("addi_alu", F_ALUC, 32'd0); chk();
      tick(); tick();

      mem_ready = 1'b0;
      e("wd_st0", F_ST, 32'd0); e("wd_irw0", F_IRW, 32'd0); chk();
      tick(); tick(); tick();
      e("wd_st3", F_ST, 32'd0); e("wd_trap3", F_TRAP, 32'd0); chk();
      tick();
      e("wd_st4", F_ST, 32'd15); e("wd_trap", F_TRAP, 32'd1); e("wd_mreq", F_MREQ, 32'd0);
      e4("wd_off_st", F_ST, 32'd0); chk();
      tick(); e("wd_stuck", F_ST, 32'd15); chk();

      reset = 1'b0;
      e("wd_rst_st", F_ST, 32'd0); e("wd_rst_trap", F_TRAP, 32'd0); chk();
      tick();
      reset = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b1;
      e("wd_late_st", F_ST, 32'd0); e("wd_late_irw", F_IRW, 32'd1); chk();
      tick(); e("wd_late_dec", F_ST, 32'd1); e("wd_late_trap", F_TRAP, 32'd0); chk();

      op = OP_L;
      tick(); tick();
      mem_ready = 1'b0;
      e("mrd_st", F_ST, 32'd3); chk();
      reset = 1'b0; mem_ready = 1'b1;
      e("mrd_rst_st", F_ST, 32'd0); e("mrd_rst_mreq", F_MREQ, 32'd0); e("mrd_rst_irw", F_IRW, 32'd0);
      e4("mrd_rst_st", F_ST, 32'd0); chk();
      tick(); e("mrd_held_st", F_ST, 32'd0); e("mrd_held_mreq", F_MREQ, 32'd0); chk();
      reset = 1'b1;

      fetch(7'b1111111);
      tick(); e("ill_st", F_ST, 32'd15); e("ill_trap", F_TRAP, 32'd1); e4("ill_st", F_ST, 32'd15); chk();
      tick(); e("ill_hold", F_ST, 32'd15); e("ill_pcw", F_PCW, 32'd0); chk();
      reset = 1'b0;
      #2 reset = 1'b1;

      run_lw();
      run_r(3'b000, 1'b0, 32'd0);
      run_br(3'b000, 1'b1, 1'b0, 32'd1);
`ifdef CTRL_PERF_CNT_EN
      e("instret", F_IRET, 32'd3); e4("instret", F_IRET, 32'd3); chk();
`endif

      fetch(OP_R);
      funct3 = 3'b101; funct7b5 = 1'b1;
      tick(); e4("sra_alu", F_ALUC, 32'd8); chk();
      tick(); e("w3_unsup_st", F_ST, 32'd15); e("w3_unsup_trap", F_TRAP, 32'd1);
      e4("w4_sra_wb", F_ST, 32'd8); chk();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
